seg7_scan_display: RTL and testbench

Parametrised seven-segment display controller that replaces the fixed four-digit hex lookup on the board top level. Drives DIGITS hex digits either as static parallel segment buses (DE1 HEX0..HEX3 style) or as a time-multiplexed common-anode scan. Adds a tear-free load handshake, leading-zero blanking, per-digit decimal points and per-digit blinking. Sits between the CPU-side counter/status register and the board display pins.

---
 rtl/seg7_scan_display.sv | 180 ++++++++++++++++++
 tb/tb_seg7_scan_display.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_display.sv
// Seven-segment display controller: static parallel buses plus a common-anode
// multiplexed scan, with frame-synchronous loading, leading-zero blanking and blink.
module seg7_scan_display #(
    parameter int DIGITS       = 4,
    parameter int SCAN_DIV     = 50000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     blink_in,
    input  logic                  load,
    input  logic                  blank_lz,
    output logic                  pending,
    output logic                  frame,
    output logic [7*DIGITS-1:0]   seg_par,
    output logic [7:0]            seg,
    output logic [DIGITS-1:0]     dig_sel
);

    localparam int PRESC_W = $clog2(SCAN_DIV);
    localparam int IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int FCNT_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: glyph = 7'h40;
            4'h1: glyph = 7'h79;
            4'h2: glyph = 7'h24;
            4'h3: glyph = 7'h30;
            4'h4: glyph = 7'h19;
            4'h5: glyph = 7'h12;
            4'h6: glyph = 7'h02;
            4'h7: glyph = 7'h78;
            4'h8: glyph = 7'h00;
            4'h9: glyph = 7'h10;
            4'hA: glyph = 7'h08;
            4'hB: glyph = 7'h03;
            4'hC: glyph = 7'h46;
            4'hD: glyph = 7'h21;
            4'hE: glyph = 7'h06;
            default: glyph = 7'h0E;
        endcase
    endfunction

    logic [4*DIGITS-1:0] pend_val_q, pend_val_d, disp_val_q, disp_val_d;
    logic [DIGITS-1:0]   pend_dp_q, pend_dp_d, disp_dp_q, disp_dp_d;
    logic [DIGITS-1:0]   pend_bl_q, pend_bl_d, disp_bl_q, disp_bl_d;
    logic                pending_q, pending_d;
    logic [PRESC_W-1:0]  presc_q, presc_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [FCNT_W-1:0]   fcnt_q, fcnt_d;
    logic                phase_q, phase_d;
    logic                frame_q, frame_d;
    logic [7*DIGITS-1:0] seg_par_q, seg_par_d;
    logic [7:0]          seg_q, seg_d;
    logic [DIGITS-1:0]   dig_sel_q, dig_sel_d;

    logic tick, last_idx, boundary;
    logic [DIGITS-1:0] blank;
    logic              upper_zero;

    assign tick     = (presc_q == PRESC_W'(SCAN_DIV - 1));
    assign last_idx = (idx_q == IDX_W'(DIGITS - 1));
    assign boundary = tick && last_idx;

    always_comb begin
        presc_d    = tick ? '0 : presc_q + PRESC_W'(1);
        idx_d      = idx_q;
        fcnt_d     = fcnt_q;
        phase_d    = phase_q;
        pend_val_d = pend_val_q;
        pend_dp_d  = pend_dp_q;
        pend_bl_d  = pend_bl_q;
        pending_d  = pending_q;
        disp_val_d = disp_val_q;
        disp_dp_d  = disp_dp_q;
        disp_bl_d  = disp_bl_q;

        if (tick) begin
            idx_d = last_idx ? '0 : idx_q + IDX_W'(1);
        end

        if (load) begin
            pend_val_d = value;
            pend_dp_d  = dp_in;
            pend_bl_d  = blink_in;
            pending_d  = 1'b1;
        end

        // A load landing on the boundary bypasses the pending set entirely.
        if (boundary) begin
            if (load) begin
                disp_val_d = value;
                disp_dp_d  = dp_in;
                disp_bl_d  = blink_in;
                pending_d  = 1'b0;
            end else if (pending_q) begin
                disp_val_d = pend_val_q;
                disp_dp_d  = pend_dp_q;
                disp_bl_d  = pend_bl_q;
                pending_d  = 1'b0;
            end

            if (fcnt_q == FCNT_W'(BLINK_FRAMES - 1)) begin
                fcnt_d  = '0;
                phase_d = ~phase_q;
            end else begin
                fcnt_d = fcnt_q + FCNT_W'(1);
            end
        end
    end

    always_comb begin
        blank      = '0;
        upper_zero = 1'b1;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            upper_zero = upper_zero && (disp_val_q[4*k +: 4] == 4'h0);
            blank[k]   = (blank_lz && (k != 0) && upper_zero) || (phase_q && disp_bl_q[k]);
        end
    end

    always_comb begin
        seg_par_d = '1;
        seg_d     = 8'hFF;
        dig_sel_d = '1;
        frame_d   = boundary;
        for (int k = 0; k < DIGITS; k++) begin
            seg_par_d[7*k +: 7] = blank[k] ? 7'h7F : glyph(disp_val_q[4*k +: 4]);
            dig_sel_d[k]        = (idx_q != IDX_W'(k));
            if (idx_q == IDX_W'(k)) begin
                seg_d = blank[k] ? 8'hFF : {~disp_dp_q[k], glyph(disp_val_q[4*k +: 4])};
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_val_q <= '0;
            pend_dp_q  <= '0;
            pend_bl_q  <= '0;
            pending_q  <= 1'b0;
            disp_val_q <= '0;
            disp_dp_q  <= '0;
            disp_bl_q  <= '0;
            presc_q    <= '0;
            idx_q      <= '0;
            fcnt_q     <= '0;
            phase_q    <= 1'b0;
            frame_q    <= 1'b0;
            seg_par_q  <= '1;
            seg_q      <= 8'hFF;
            dig_sel_q  <= '1;
        end else begin
            pend_val_q <= pend_val_d;
            pend_dp_q  <= pend_dp_d;
            pend_bl_q  <= pend_bl_d;
            pending_q  <= pending_d;
            disp_val_q <= disp_val_d;
            disp_dp_q  <= disp_dp_d;
            disp_bl_q  <= disp_bl_d;
            presc_q    <= presc_d;
            idx_q      <= idx_d;
            fcnt_q     <= fcnt_d;
            phase_q    <= phase_d;
            frame_q    <= frame_d;
            seg_par_q  <= seg_par_d;
            seg_q      <= seg_d;
            dig_sel_q  <= dig_sel_d;
        end
    end

    assign pending = pending_q;
    assign frame   = frame_q;
    assign seg_par = seg_par_q;
    assign seg     = seg_q;
    assign dig_sel = dig_sel_q;

endmodule

// File: tb/tb_seg7_scan_display.sv
// Scoreboard bench for seg7_scan_display: a time-based reference model queues the
// expected outputs for each clock edge, and a monitor compares them after the edge.
module tb_seg7_scan_display;

    localparam int DIGITS       = 4;
    localparam int SCAN_DIV     = 4;
    localparam int BLINK_FRAMES = 2;
    localparam int FP           = SCAN_DIV * DIGITS;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] value = '0;
    logic [3:0]  dp_in = '0, blink_in = '0;
    logic        load = 1'b0, blank_lz = 1'b0;
    logic        pending, frame;
    logic [27:0] seg_par;
    logic [7:0]  seg;
    logic [3:0]  dig_sel;

    typedef struct packed {
        logic        pending;
        logic        frame;
        logic [27:0] seg_par;
        logic [7:0]  seg;
        logic [3:0]  dig_sel;
    } exp_t;

    localparam exp_t RST_EXP = '{pending: 1'b0, frame: 1'b0, seg_par: '1, seg: 8'hFF, dig_sel: 4'hF};

    exp_t expq[$];
    exp_t mon_want, mon_got;
    int   checks = 0, errors = 0;
    logic [6:0] gly [16];

    // Reference model state: edge number since reset release, shown and waiting sets.
    int          e = 0;
    logic [15:0] disp_v = '0, pset_v = '0;
    logic [3:0]  disp_dp = '0, disp_bl = '0, pset_dp = '0, pset_bl = '0;
    bit          pend = 0;
    logic [15:0] cur_v = '0;
    logic [3:0]  cur_dp = '0, cur_bl = '0;
    logic        cur_lz = 1'b0;

    seg7_scan_display #(
        .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .BLINK_FRAMES(BLINK_FRAMES)
    ) dut (
        .clk(clk), .reset_n(reset_n), .value(value), .dp_in(dp_in),
        .blink_in(blink_in), .load(load), .blank_lz(blank_lz),
        .pending(pending), .frame(frame), .seg_par(seg_par), .seg(seg), .dig_sel(dig_sel)
    );

    initial forever #5 clk = ~clk;

    task automatic compare(input string name, input exp_t got, input exp_t want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s t=%0t got pend=%b frame=%b seg_par=%h seg=%h dig_sel=%h want pend=%b frame=%b seg_par=%h seg=%h dig_sel=%h",
                     name, $time, got.pending, got.frame, got.seg_par, got.seg, got.dig_sel,
                     want.pending, want.frame, want.seg_par, want.seg, want.dig_sel);
        end
    endtask

    task automatic step(input logic rn, input logic ld, input logic [15:0] v,
                        input logic [3:0] dp, input logic [3:0] bl);
        exp_t        x;
        int          idx, fb;
        bit          ph, bnd, blk;
        logic [15:0] upper;
        logic [3:0]  nib;
        logic        prev_rn;
        @(negedge clk);
        prev_rn  = reset_n;
        reset_n  = rn;
        load     = ld;
        value    = v;
        dp_in    = dp;
        blink_in = bl;
        blank_lz = cur_lz;
        if (!rn) begin
            if (prev_rn) begin
                #1;
                compare("async_reset", {pending, frame, seg_par, seg, dig_sel}, RST_EXP);
            end
            e = 0; disp_v = '0; disp_dp = '0; disp_bl = '0;
            pset_v = '0; pset_dp = '0; pset_bl = '0; pend = 0;
            expq.push_back(RST_EXP);
        end else begin
            idx = (e / SCAN_DIV) % DIGITS;
            fb  = e / FP;
            ph  = ((fb / BLINK_FRAMES) % 2) == 1;
            bnd = ((e + 1) % FP) == 0;
            x   = RST_EXP;
            for (int k = 0; k < DIGITS; k++) begin
                upper = disp_v >> (4 * k);
                nib   = upper[3:0];
                blk   = (cur_lz && k != 0 && upper == 16'h0) || (ph && disp_bl[k]);
                x.seg_par[7*k +: 7] = blk ? 7'h7F : gly[nib];
                if (k == idx) x.seg = blk ? 8'hFF : {~disp_dp[k], gly[nib]};
            end
            x.dig_sel = ~(4'b0001 << idx);
            x.frame   = bnd;
            if (ld) begin
                pset_v = v; pset_dp = dp; pset_bl = bl; pend = 1;
            end
            if (bnd && pend) begin
                disp_v = pset_v; disp_dp = pset_dp; disp_bl = pset_bl; pend = 0;
            end
            x.pending = pend;
            e++;
            expq.push_back(x);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, cur_v, cur_dp, cur_bl);
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] bl);
        cur_v = v; cur_dp = dp; cur_bl = bl;
        step(1'b1, 1'b1, v, dp, bl);
    endtask

    // Idle until the next driven edge has the given position within the frame.
    task automatic align(input int pos);
        while ((e % FP) != pos) idle(1);
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        if (expq.size() > 0) begin
            mon_want = expq.pop_front();
            mon_got  = {pending, frame, seg_par, seg, dig_sel};
            compare("outputs", mon_got, mon_want);
        end
    end

    initial begin
        gly = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0, '0, '0);

        idle(3);
        do_load(16'h12AF, 4'h0, 4'h0);
        idle(40);

        align(2);
        do_load(16'h1111, 4'h0, 4'h0);
        idle(2);
        do_load(16'h2222, 4'h0, 4'h0);
        idle(20);
        align(FP - 1);
        do_load(16'h3456, 4'h5, 4'h0);
        idle(20);

        do_load(16'h0050, 4'h0, 4'h0);
        cur_lz = 1'b1;
        idle(24);
        cur_lz = 1'b0;
        idle(20);

        do_load(16'h8421, 4'b0010, 4'b0010);
        idle(90);

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(19) == 0) cur_lz = ~cur_lz;
            if ($urandom_range(5) == 0) begin
                if ($urandom_range(2) == 0)
                    do_load(16'($urandom_range(255)), 4'($urandom), 4'($urandom));
                else
                    do_load(16'($urandom), 4'($urandom), 4'($urandom));
            end else begin
                idle(1);
            end
        end

        align(5);
        do_load(16'hABCD, 4'hF, 4'h0);
        idle(2);
        step(1'b0, 1'b0, cur_v, cur_dp, cur_bl);
        idle(40);

        @(negedge clk);
        @(negedge clk);
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d queued entries want 0", expq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
